if_prefetch_stage: RTL and testbench

IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

---
 rtl/if_prefetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Instruction-fetch prefetch stage. It issues in-order fetch requests to
// instruction memory, buffers the returned words together with their PCs in
// a small FIFO, and presents the FIFO head to decode with zero-latency
// dequeue. A redirect (branch/jump/trap) flushes the buffer and restarts
// fetching at the new target. Responses still in flight for the old stream
// are dropped while the block sits in DISCARD.
//
// Parameters
//   DATA_WIDTH  instruction word width
//   FIFO_DEPTH  prefetch buffer entries (power of 2, >= 2)
//   PC_STEP     byte increment per fetched word
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   boot_add       start address, sampled in BOOT
//   redirect_i     redirect strobe
//   redirect_pc_i  redirect target
//   imem_req_o     fetch request
//   imem_addr_o    fetch address (current fetch PC)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  in-order response valid
//   imem_rdata_i   response word
//   id_valid_o     buffer head valid to decode
//   id_ready_i     decode accepts head
//   id_pc_o        PC of head entry (0 when empty)
//   id_instr_o     instruction of head entry (0 when empty)
//   fifo_count_o   occupied buffer entries
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PC_STEP    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   boot_add,
  input  logic                          redirect_i,
  input  logic [31:0]                   redirect_pc_i,
  output logic                          imem_req_o,
  output logic [31:0]                   imem_addr_o,
  input  logic                          imem_gnt_i,
  input  logic                          imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         imem_rdata_i,
  output logic                          id_valid_o,
  input  logic                          id_ready_i,
  output logic [31:0]                   id_pc_o,
  output logic [DATA_WIDTH-1:0]         id_instr_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Credit limit, one bit wider than the counters so count + outstanding
  // cannot overflow in the comparison.
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_rsp_pc;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;

  // Buffer storage; read combinationally at the head pointer.
  logic [31:0]           r_pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];

  logic               w_credit_ok;
  logic               w_fire;
  logic               w_rsp_ok;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_out_next;

  // Requests are only issued while the buffer plus everything already in
  // flight still fits, so a response always finds a free slot.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_W;
  assign imem_req_o  = (r_state == ST_RUN) && w_credit_ok;
  assign imem_addr_o = r_fetch_pc;

  assign w_fire   = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok = imem_rvalid_i && (r_outstanding != '0);
  // Responses are only kept in RUN and never in a redirect cycle; in every
  // other case they belong to an abandoned stream.
  assign w_push   = w_rsp_ok && (r_state == ST_RUN) && !redirect_i;

  assign id_valid_o = (r_state == ST_RUN) && (r_count != '0);
  assign w_pop      = id_valid_o && id_ready_i && !redirect_i;

  assign id_pc_o      = (r_count != '0) ? r_pc_mem[r_rd_ptr]    : '0;
  assign id_instr_o   = (r_count != '0) ? r_instr_mem[r_rd_ptr] : '0;
  assign fifo_count_o = r_count;

  // Outstanding count after this cycle, including a grant issued in a
  // redirect cycle (it is stale and must still be drained).
  assign w_out_next = r_outstanding + CNT_W'(w_fire) - CNT_W'(w_rsp_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= '0;
      r_rsp_pc      <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_i) begin
        r_fetch_pc <= redirect_pc_i;
        r_rsp_pc   <= redirect_pc_i;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        if (r_state == ST_DISCARD) begin
          r_state <= ST_DISCARD;
        end else if (w_out_next == '0) begin
          r_state <= ST_RUN;
        end else begin
          r_state <= ST_DISCARD;
        end
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_fetch_pc <= boot_add;
            r_rsp_pc   <= boot_add;
            r_state    <= ST_RUN;
          end
          ST_RUN: begin
            if (w_fire) begin
              r_fetch_pc <= r_fetch_pc + 32'(PC_STEP);
            end
            if (w_push) begin
              r_rsp_pc <= r_rsp_pc + 32'(PC_STEP);
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
          end
          ST_DISCARD: begin
            // Leave once the last stale response has been drained.
            if (r_outstanding == '0) begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_BOOT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_rsp_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata_i;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (r_outstanding != '0));

  a_out_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_outstanding <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int STEP  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   boot_add = '0;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_pc_i = '0;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_gnt_i = 1'b0;
  logic          imem_rvalid_i = 1'b0;
  logic [DW-1:0] imem_rdata_i = '0;
  logic          id_valid_o;
  logic          id_ready_i = 1'b0;
  logic [31:0]   id_pc_o;
  logic [DW-1:0] id_instr_o;
  logic [CW-1:0] fifo_count_o;

  if_prefetch_stage #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PC_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .boot_add(boot_add),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  // Memory-side request record and decode-side buffer entry of the model.
  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mem_q[$];     // granted requests awaiting a response (in order)
  ent_t        buf_q[$];     // words the stage should currently hold
  logic [31:0] exp_fetch;    // next address the stage should request
  logic [31:0] exp_rsp;      // PC the next kept response belongs to
  int          stale;        // responses still owed to an abandoned stream
  int          n_drop;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int gnt_pct = 100, rdy_pct = 100, lat_max = 0;
  bit rsp_en = 1'b1, verbose = 1'b1;

  int          grant_cnt;
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_cyc[$];
  logic        last_req, last_valid, last_rvalid;
  logic [CW-1:0] last_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    grant_cnt = 0;
    grant_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    n_drop = 0;
  endtask

  // Reset is asserted in the middle of the current cycle so its effect on
  // the outputs is seen before any clock edge.
  task automatic do_reset(input logic [31:0] boot);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_req",   imem_req_o,   0);
    check_eq("rst_valid", id_valid_o,   0);
    check_eq("rst_pc",    id_pc_o,      0);
    check_eq("rst_instr", id_instr_o,   0);
    check_eq("rst_count", fifo_count_o, 0);
    mem_q.delete();
    buf_q.delete();
    stale = 0;
    exp_fetch = boot;
    exp_rsp = boot;
    boot_add = boot;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("boot_req", imem_req_o, 0);
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, then
  // advance the model to what the next rising edge should produce.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit          rsp_now, fire, pop_exp;
    logic [31:0] rsp_addr;
    @(negedge clk);
    cyc++;
    rsp_now  = rsp_en && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    rsp_addr = rsp_now ? mem_q[0].addr : 32'h0;
    imem_gnt_i    = int'($urandom_range(99)) < gnt_pct;
    id_ready_i    = int'($urandom_range(99)) < rdy_pct;
    imem_rvalid_i = rsp_now;
    imem_rdata_i  = rsp_now ? mem_word(rsp_addr) : $urandom;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    #1;
    last_req = imem_req_o;
    last_valid = id_valid_o;
    last_count = fifo_count_o;
    last_rvalid = rsp_now;

    check_eq("fifo_count", fifo_count_o, buf_q.size());
    check_eq("id_valid", id_valid_o, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      check_eq("id_pc", id_pc_o, buf_q[0].pc);
      check_eq("id_instr", id_instr_o, buf_q[0].instr);
    end else begin
      check_eq("id_pc_empty", id_pc_o, 0);
      check_eq("id_instr_empty", id_instr_o, 0);
    end
    if (imem_req_o) begin
      check_eq("credit", (buf_q.size() + mem_q.size()) < DEPTH, 1);
      check_eq("req_while_stale", stale, 0);
      check_eq("imem_addr", imem_addr_o, exp_fetch);
    end

    fire = imem_req_o && imem_gnt_i;
    if (rsp_now) void'(mem_q.pop_front());
    if (fire) begin
      mem_q.push_back('{addr: imem_addr_o, due: cyc + 1 + int'($urandom_range(lat_max))});
      grant_cnt++;
      grant_log.push_back(imem_addr_o);
    end
    if (redir) begin
      buf_q.delete();
      exp_fetch = tgt;
      exp_rsp = tgt;
      stale = mem_q.size();
      if (rsp_now) n_drop++;
    end else begin
      if (fire) exp_fetch = exp_fetch + STEP;
      pop_exp = (buf_q.size() != 0) && id_ready_i;
      if (pop_exp) begin
        if (verbose) $display("[TB] cyc %0d pop pc=0x%08h instr=0x%08h", cyc, buf_q[0].pc, buf_q[0].instr);
        pop_log.push_back(buf_q[0].pc);
        pop_cyc.push_back(32'(cyc));
        void'(buf_q.pop_front());
      end
      if (rsp_now) begin
        if (stale > 0) begin
          stale--;
          n_drop++;
        end else begin
          buf_q.push_back('{pc: exp_rsp, instr: mem_word(rsp_addr)});
          exp_rsp = exp_rsp + STEP;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] tgt;
    int guard;

    // Boot at 0x100 with a single-cycle memory and decode always ready.
    $display("[TB] scenario: boot stream");
    gnt_pct = 100; rdy_pct = 100; lat_max = 0; rsp_en = 1'b1;
    do_reset(32'h100);
    repeat (8) step(1'b0, 32'h0);
    check_eq("boot_first_req", qget(grant_log, 0), 32'h100);
    check_eq("boot_pop0", qget(pop_log, 0), 32'h100);
    check_eq("boot_pop1", qget(pop_log, 1), 32'h104);
    check_eq("boot_pop2", qget(pop_log, 2), 32'h108);
    check_eq("boot_rate01", qget(pop_cyc, 1) - qget(pop_cyc, 0), 1);
    check_eq("boot_rate12", qget(pop_cyc, 2) - qget(pop_cyc, 1), 1);

    // Decode stalled: the buffer fills to exactly DEPTH and requests stop.
    $display("[TB] scenario: backpressure");
    rdy_pct = 0;
    do_reset(32'h200);
    repeat (12) step(1'b0, 32'h0);
    check_eq("bp_grants", grant_cnt, DEPTH);
    check_eq("bp_req_off", last_req, 0);
    check_eq("bp_count_full", last_count, DEPTH);
    rdy_pct = 100;
    step(1'b0, 32'h0);
    rdy_pct = 0;
    grant_cnt = 0;
    step(1'b0, 32'h0);
    check_eq("bp_count_after_pop", last_count, DEPTH - 1);
    repeat (7) step(1'b0, 32'h0);
    check_eq("bp_one_refill", grant_cnt, 1);
    check_eq("bp_count_refull", last_count, DEPTH);

    // Redirect with two requests still in flight.
    $display("[TB] scenario: redirect with in-flight");
    rdy_pct = 100; rsp_en = 1'b0;
    do_reset(32'h400);
    repeat (2) step(1'b0, 32'h0);
    gnt_pct = 0;
    step(1'b1, 32'h2000);
    check_eq("rdr_inflight", mem_q.size(), 2);
    clear_logs();
    rsp_en = 1'b1; gnt_pct = 100;
    repeat (12) step(1'b0, 32'h0);
    check_eq("rdr_dropped", n_drop, 2);
    check_eq("rdr_first_req", qget(grant_log, 0), 32'h2000);
    check_eq("rdr_first_pop", qget(pop_log, 0), 32'h2000);

    // Redirect, would-be pop and a response in the same cycle.
    $display("[TB] scenario: simultaneous redirect/pop/response");
    rdy_pct = 0; rsp_en = 1'b0;
    do_reset(32'h800);
    repeat (4) step(1'b0, 32'h0);
    rsp_en = 1'b1;
    repeat (2) step(1'b0, 32'h0);
    rdy_pct = 100;
    step(1'b1, 32'h3000);
    check_eq("sim_valid_pre", last_valid, 1);
    check_eq("sim_rvalid_pre", last_rvalid, 1);
    clear_logs();
    rsp_en = 1'b0;
    step(1'b0, 32'h0);
    check_eq("sim_count_after", last_count, 0);
    check_eq("sim_valid_after", last_valid, 0);
    rsp_en = 1'b1;
    repeat (12) step(1'b0, 32'h0);
    check_eq("sim_first_pop", qget(pop_log, 0), 32'h3000);

    // Address wrap at the top of the 32-bit space.
    $display("[TB] scenario: address wrap");
    lat_max = 2;
    do_reset(32'h0);
    step(1'b1, 32'hFFFF_FFF8);
    clear_logs();
    repeat (14) step(1'b0, 32'h0);
    check_eq("wrap_req0", qget(grant_log, 0), 32'hFFFF_FFF8);
    check_eq("wrap_req1", qget(grant_log, 1), 32'hFFFF_FFFC);
    check_eq("wrap_req2", qget(grant_log, 2), 32'h0000_0000);
    check_eq("wrap_pop2", qget(pop_log, 2), 32'h0000_0000);

    // Reset while three entries are buffered.
    $display("[TB] scenario: mid-stream reset");
    rdy_pct = 0; lat_max = 0;
    do_reset(32'h100);
    guard = 0;
    do begin
      step(1'b0, 32'h0);
      guard++;
    end while (last_count != 3 && guard < 20);
    check_eq("mid_pre_count", last_count, 3);
    check_eq("mid_pre_valid", last_valid, 1);
    do_reset(32'h100);
    rdy_pct = 100;
    repeat (6) step(1'b0, 32'h0);
    check_eq("mid_restart_pop", qget(pop_log, 0), 32'h100);

    // Random traffic with occasional redirects, some near the wrap point.
    $display("[TB] scenario: random traffic");
    verbose = 1'b0;
    gnt_pct = 70; rdy_pct = 60; lat_max = 3; rsp_en = 1'b1;
    do_reset($urandom & 32'hFFFF_FFFC);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + ($urandom_range(3) * 4);
        else tgt = $urandom & 32'hFFFF_FFFC;
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end
    check_eq("rand_progress", pop_log.size() > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
